// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one async_fifo write port
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 8,
  parameter int CNTW  = 16
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     cfg_almst_hold,
  output logic                     wreq,
  output logic [DSIZE-1:0]         wdata,
  input  logic                     wfull,
  input  logic                     wfull_almst,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [CNTW-1:0]          wr_cnt
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last_id;
  logic [7:0]       r_burst_cnt;
  logic [CNTW-1:0]  r_wr_cnt;

  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_cand;
  logic             w_start;
  logic             w_bursting;
  logic             w_gvalid;
  logic [DSIZE-1:0] w_gdata;
  logic             w_last_word;

  // Scan requesters starting just after the last winner, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = r_last_id;
    for (int j = 0; j < NREQ; j++) begin
      w_cand = (w_cand == IDW'(NREQ - 1)) ? '0 : w_cand + IDW'(1);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_gvalid = req_valid[i];
        w_gdata  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign w_bursting  = (r_state == S_BURST);
  assign w_start     = w_found & ~wfull & ~(cfg_almst_hold & wfull_almst);
  assign w_last_word = (r_burst_cnt == 8'(BURST - 1));

  assign wreq  = w_bursting & w_gvalid & ~wfull;
  assign wdata = wreq ? w_gdata : '0;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_bursting & ~wfull & (r_grant_id == IDW'(i));
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = w_bursting;
  assign wr_cnt   = r_wr_cnt;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= S_IDLE;
      r_grant_id  <= '0;
      r_last_id   <= IDW'(NREQ - 1);
      r_burst_cnt <= '0;
      r_wr_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (wreq) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_wr_cnt    <= r_wr_cnt + CNTW'(1);
          end
          // A released requester ends the burst even while the FIFO is full.
          if ((wreq && w_last_word) || !w_gvalid) begin
            r_state   <= S_IDLE;
            r_last_id <= r_grant_id;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter against a transaction model
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 8;
  localparam int CNTW  = 16;

  logic                    wclk = 1'b0;
  logic                    wrst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*DSIZE-1:0]   req_data = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    cfg_almst_hold = 1'b0;
  logic                    wreq;
  logic [DSIZE-1:0]        wdata;
  logic                    wfull = 1'b0;
  logic                    wfull_almst = 1'b0;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;
  logic [CNTW-1:0]         wr_cnt;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST), .CNTW(CNTW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cfg_almst_hold(cfg_almst_hold), .wreq(wreq), .wdata(wdata),
    .wfull(wfull), .wfull_almst(wfull_almst), .grant_id(grant_id), .busy(busy), .wr_cnt(wr_cnt)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q [NREQ][$];
  logic [NREQ-1:0] t_pause = '0;
  logic t_wfull = 1'b0, t_almst = 1'b0, t_hold = 1'b0;

  bit m_busy;
  int m_grant, m_last, m_len, m_total;
  bit prev_busy;
  int dut_bursts;
  int grant_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NREQ-1:0] e_ready;
    logic e_wreq;
    logic [7:0] e_wdata;
    e_ready = '0; e_wreq = 1'b0; e_wdata = '0;
    if (m_busy) begin
      e_ready[m_grant] = !wfull;
      e_wreq = req_valid[m_grant] && !wfull;
      if (e_wreq) e_wdata = q[m_grant][0];
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("grant_id", 32'(grant_id), m_grant);
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("wreq", 32'(wreq), 32'(e_wreq));
    check("wdata", 32'(wdata), 32'(e_wdata));
    check("wr_cnt", 32'(wr_cnt), m_total % (1 << CNTW));
    if (busy && !prev_busy) begin
      dut_bursts++;
      grant_log.push_back(int'(grant_id));
    end
    prev_busy = busy;
    if (m_busy) begin
      if (e_wreq) begin
        void'(q[m_grant].pop_front());
        m_total++;
        m_len++;
      end
      if ((e_wreq && m_len == BURST) || !req_valid[m_grant]) begin
        m_busy = 1'b0;
        m_last = m_grant;
      end
    end else if ((|req_valid) && !wfull && !(cfg_almst_hold && wfull_almst)) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req_valid[(m_last + k) % NREQ]) begin
          m_grant = (m_last + k) % NREQ;
          break;
        end
      end
      m_busy = 1'b1;
      m_len  = 0;
    end
  endtask

  task automatic cycle();
    @(posedge wclk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() != 0) && !t_pause[i];
      req_data[i*DSIZE +: DSIZE] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
    wfull = t_wfull;
    wfull_almst = t_almst;
    cfg_almst_hold = t_hold;
    @(negedge wclk);
    model_step();
  endtask

  task automatic do_reset();
    @(posedge wclk); #2;
    wrst_n = 1'b0;
    req_valid = '0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_wreq", 32'(wreq), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr_cnt", 32'(wr_cnt), 0);
    check("rst_grant", 32'(grant_id), 0);
    m_busy = 1'b0; m_grant = 0; m_last = NREQ - 1; m_len = 0; m_total = 0;
    prev_busy = 1'b0; dut_bursts = 0; grant_log.delete();
    t_pause = '0; t_wfull = 1'b0; t_almst = 1'b0; t_hold = 1'b0;
    @(posedge wclk); #3;
    wrst_n = 1'b1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b1;
    return m_busy;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    cycle();
    cycle();
  endtask

  initial begin
    int n;
    do_reset();

    // Single requester, 33 words: 8,8,8,8,1
    for (int w = 1; w <= 33; w++) q[0].push_back(8'(w));
    drain(200);
    check("t1_wr_cnt", 32'(wr_cnt), 33);
    check("t1_bursts", dut_bursts, 5);

    // All requesters competing
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < 16; w++) q[i].push_back(8'(i * 64 + w));
    drain(400);
    for (int b = 0; b < 6; b++) check($sformatf("t2_order%0d", b), grant_log[b], b % NREQ);
    check("t2_wr_cnt", 32'(wr_cnt), 64);

    // FIFO full in the middle of a burst
    do_reset();
    for (int w = 0; w < BURST; w++) q[0].push_back(8'(8'h30 + w));
    n = 0;
    while (m_len < 3 && n < 50) begin cycle(); n++; end
    if (n >= 50) check("t3_timeout", 1, 0);
    t_wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t3_full_wreq", 32'(wreq), 0);
      check("t3_full_ready", 32'(req_ready), 0);
    end
    t_wfull = 1'b0;
    drain(100);
    check("t3_wr_cnt", 32'(wr_cnt), BURST);
    check("t3_bursts", dut_bursts, 1);

    // Almost-full hold gates only the start of a burst
    do_reset();
    t_hold = 1'b1; t_almst = 1'b1;
    for (int w = 0; w < 4; w++) q[1].push_back(8'(8'h50 + w));
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("t4_held", 32'(busy), 0);
    end
    t_almst = 1'b0;
    cycle();
    check("t4_arb_cycle", 32'(busy), 0);
    cycle();
    check("t4_started", 32'(busy), 1);
    check("t4_grant", 32'(grant_id), 1);
    drain(100);
    t_hold = 1'b0; t_almst = 1'b1;
    for (int w = 0; w < 2; w++) q[2].push_back(8'(8'h60 + w));
    cycle();
    cycle();
    check("t4_nohold", 32'(busy), 1);
    drain(100);
    t_almst = 1'b0;

    // Requester release hands over to the next valid requester
    do_reset();
    for (int w = 0; w < 3; w++) q[1].push_back(8'(8'h70 + w));
    for (int w = 0; w < 5; w++) q[2].push_back(8'(8'h80 + w));
    n = 0;
    while (!(busy && grant_id == 2) && n < 50) begin cycle(); n++; end
    if (n >= 50) check("t5_timeout", 1, 0);
    check("t5_wr_cnt", 32'(wr_cnt), 3);
    drain(100);
    check("t5_first", grant_log[0], 1);

    // Reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < BURST; w++) q[i].push_back(8'(8'h90 + i * 16 + w));
    n = 0;
    while (m_len < 5 && n < 50) begin cycle(); n++; end
    if (n >= 50) check("t6_timeout", 1, 0);
    do_reset();
    drain(100);
    check("t6_first", grant_log[0], 0);
    check("t6_second", grant_log[1], 1);
    check("t6_wr_cnt", 32'(wr_cnt), 3 + BURST);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() < 6 && $urandom_range(0, 3) == 0) q[i].push_back(8'($urandom));
        t_pause[i] = ($urandom_range(0, 9) == 0);
      end
      t_wfull = ($urandom_range(0, 5) == 0);
      t_almst = ($urandom_range(0, 3) == 0);
      if (c % 100 == 0) t_hold = 1'($urandom_range(0, 1));
      cycle();
    end
    t_pause = '0; t_wfull = 1'b0; t_almst = 1'b0; t_hold = 1'b0;
    drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
